rv32i_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Holds the fetch PC, issues word requests to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a small FIFO. The FIFO presents `{instr, pc, pc+4}` to the decode stage, where `instr[6:0]` feeds the main controller's opcode input. Redirects from the branch unit flush buffered and in-flight fetches and restart fetching at the target.

---
 rtl/rv32i_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: issues word fetches to instruction memory, buffers responses
// in a small FIFO for decode, and flushes in-flight work on branch/jump redirects.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;

    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];
    // Address of each in-flight request, so responses can be tagged in order.
    logic [31:0] pcq_q        [DEPTH];

    logic          pop;
    logic          req_fire;
    logic          rsp_push;
    logic [CW+1:0] credit_sum;
    logic [CW-1:0] drop_val;

    // Low address bits of the redirect target are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshakes and outputs
    always_comb begin
        if_valid   = (count_q != '0) & ~redirect_valid;
        pop        = if_valid & id_ready;
        credit_sum = {2'b00, outstanding_q} + {2'b00, count_q} - {{(CW + 1){1'b0}}, pop};

        // Gated by rst_n so the request line is low for the whole reset interval.
        imem_req_valid = rst_n & (state_q == ST_RUN) & ~redirect_valid & (credit_sum < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_push       = imem_rsp_valid & (state_q == ST_RUN) & ~redirect_valid;

        if_instr    = fifo_instr_q[rd_ptr_q];
        if_pc       = fifo_pc_q[rd_ptr_q];
        if_pc_plus4 = fifo_pc_q[rd_ptr_q] + 32'd4;
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        pcq_rd_d      = pcq_rd_q;
        pcq_wr_d      = pcq_wr_q;
        drop_val      = outstanding_q - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            pcq_rd_d      = '0;
            pcq_wr_d      = '0;
            outstanding_d = drop_val;
            drop_cnt_d    = drop_val;
            state_d       = (drop_val != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + AW'(1);
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

            if (rsp_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pcq_rd_d = pcq_rd_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(rsp_push) - CW'(pop);

            if ((state_q == ST_FLUSH) && imem_rsp_valid) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
                if (drop_cnt_q == CW'(1)) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pcq_rd_q      <= pcq_rd_d;
            pcq_wr_q      <= pcq_wr_d;
        end
    end

    // Storage: cleared on reset so decode sees zeroed head fields while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
                pcq_q[i]        <= '0;
            end
        end else begin
            if (req_fire) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
            end
            if (rsp_push) begin
                fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
                fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: in-order memory model with variable latency and a
// program-order pc model; a second instance with a wrapping RESET_PC.
module tb_rv32i_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] WPC   = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, id_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        req_valid_w, rsp_valid_w, if_valid_w;
    logic [31:0] req_addr_w, rsp_data_w, if_instr_w, if_pc_w, if_pc_plus4_w;

    always #5 clk = ~clk;

    rv32i_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_ready       (id_ready)
    );

    rv32i_fetch_unit #(.RESET_PC(WPC), .DEPTH(DEPTH)) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid_w),
        .imem_req_addr  (req_addr_w),
        .imem_req_ready (1'b1),
        .imem_rsp_valid (rsp_valid_w),
        .imem_rsp_data  (rsp_data_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (if_valid_w),
        .if_instr       (if_instr_w),
        .if_pc          (if_pc_w),
        .if_pc_plus4    (if_pc_plus4_w),
        .id_ready       (1'b1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Fixed one-cycle memory for the wrapping instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_w <= 1'b0;
            rsp_data_w  <= 32'h0;
        end else begin
            rsp_valid_w <= req_valid_w;
            rsp_data_w  <= mem_word(req_addr_w);
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          redir_mode = 0;
    bit          rand_mode = 0;
    bit          ctl_id_ready = 1, ctl_req_ready = 1;
    logic [31:0] redir_tgt = 32'h0;
    logic [31:0] exp_pc = RPC, exp_req = RPC;
    int          acc_count = 0;
    bit          rd_fired = 0, rd_req_seen = 0, rd_pop_seen = 0;
    logic [31:0] rd_req_addr = 32'h0, rd_pop_pc = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model, stimulus driver and per-cycle compare against the program-order model.
    always @(negedge clk) begin
        bit rsp_now;
        if (rand_mode) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
        end else begin
            id_ready       = ctl_id_ready;
            imem_req_ready = ctl_req_ready;
        end
        redirect_valid = 1'b0;
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            exp_pc         = RPC;
            exp_req        = RPC;
        end else begin
            rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
            imem_rsp_valid = rsp_now;
            imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : 32'h0;
            if ((redir_mode == 1 && mq.size() == DEPTH && !rsp_now) ||
                (redir_mode == 2 && rsp_now)) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_tgt;
                redir_mode     = 0;
            end else if (rand_mode && $urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            #1;
            if (redirect_valid) begin
                check32("redir_if_valid_low", 32'(if_valid), 32'd0);
                check32("redir_req_low", 32'(imem_req_valid), 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check32("req_addr", imem_req_addr, exp_req);
                mq.push_back('{imem_req_addr, cyc + lat});
                exp_req = exp_req + 32'd4;
                acc_count++;
                if (rd_fired && !rd_req_seen) begin
                    rd_req_seen = 1;
                    rd_req_addr = imem_req_addr;
                end
            end
            if (rsp_now) void'(mq.pop_front());
            if (if_valid && id_ready) begin
                check32("if_pc", if_pc, exp_pc);
                check32("if_instr", if_instr, mem_word(exp_pc));
                check32("if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                if (rd_fired && !rd_pop_seen) begin
                    rd_pop_seen = 1;
                    rd_pop_pc   = if_pc;
                end
            end
            check32("in_flight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
            if (redirect_valid) begin
                exp_pc      = {redirect_pc[31:2], 2'b00};
                exp_req     = {redirect_pc[31:2], 2'b00};
                rd_fired    = 1;
                rd_req_seen = 0;
                rd_pop_seen = 0;
            end
        end
    end

    task automatic run_redirect(input int mode, input logic [31:0] tgt, input logic [31:0] exp_a);
        rd_fired    = 0;
        rd_pop_seen = 0;
        rd_req_seen = 0;
        redir_tgt   = tgt;
        redir_mode  = mode;
        for (int i = 0; i < 60 && !(rd_fired && rd_pop_seen); i++) @(negedge clk);
        #2;
        check32("redir_completed", 32'(rd_fired && rd_pop_seen), 32'd1);
        check32("redir_first_req", rd_req_addr, exp_a);
        check32("redir_first_if_pc", rd_pop_pc, exp_a);
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check32("rst_if_valid", 32'(if_valid), 32'd0);
        check32("rst_if_instr", if_instr, 32'h0);
        check32("rst_if_pc", if_pc, 32'h0);
        check32("rst_if_pc_plus4", if_pc_plus4, 32'h4);
        check32("rst_w_pc_plus4", if_pc_plus4_w, 32'h4);

        // Boot with L=1, all readies high.
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #2;
        check32("boot_req_valid", 32'(imem_req_valid), 32'd1);
        check32("boot_req_addr", imem_req_addr, 32'h0000_0100);
        check32("wrap_req_addr", req_addr_w, 32'hFFFF_FFF8);
        @(negedge clk); #2;
        check32("boot_c2_if_valid", 32'(if_valid), 32'd0);
        @(negedge clk); #2;
        check32("boot_c3_if_valid", 32'(if_valid), 32'd1);
        check32("boot_c3_if_pc", if_pc, 32'h0000_0100);
        check32("boot_c3_plus4", if_pc_plus4, 32'h0000_0104);
        check32("wrap_c3_if_pc", if_pc_w, 32'hFFFF_FFF8);
        @(negedge clk); #2;
        check32("boot_c4_if_pc", if_pc, 32'h0000_0104);
        check32("wrap_c4_if_pc", if_pc_w, 32'hFFFF_FFFC);
        check32("wrap_c4_plus4", if_pc_plus4_w, 32'h0000_0000);
        @(negedge clk); #2;
        check32("boot_c5_if_pc", if_pc, 32'h0000_0108);
        check32("wrap_c5_if_pc", if_pc_w, 32'h0000_0000);
        check32("wrap_c5_instr", if_instr_w, mem_word(32'h0));
        repeat (5) @(negedge clk);

        // Fill the FIFO, then reset asynchronously between clock edges.
        ctl_id_ready = 0;
        repeat (5) @(negedge clk); #2;
        check32("full_if_valid", 32'(if_valid), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check32("async_rst_if_valid", 32'(if_valid), 32'd0);
        check32("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check32("async_rst_if_pc", if_pc, 32'h0);
        check32("async_rst_plus4", if_pc_plus4, 32'h4);

        // Restart with decode stalled for 10 cycles.
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        acc_count = 0;
        @(negedge clk); #2;
        check32("restart_req_addr", imem_req_addr, RPC);
        repeat (9) @(negedge clk); #2;
        check32("bp_accepted", 32'(acc_count), 32'd2);
        check32("bp_if_valid", 32'(if_valid), 32'd1);
        check32("bp_if_pc", if_pc, 32'h0000_0100);
        ctl_id_ready = 1;
        repeat (12) @(negedge clk);

        // Redirect with two requests in flight (L=3), then with a same-cycle response (L=2).
        lat = 3;
        repeat (6) @(negedge clk);
        run_redirect(1, 32'h0000_2002, 32'h0000_2000);
        repeat (6) @(negedge clk);
        lat = 2;
        repeat (4) @(negedge clk);
        run_redirect(2, 32'h0000_3000, 32'h0000_3000);
        repeat (6) @(negedge clk);

        // Randomised traffic checked only by the model.
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) lat = 1 + (i / 50) % 3;
            @(negedge clk);
        end
        rand_mode = 0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
